// File: rtl/pk_mm_pkg.sv
// Shared widths, coefficient type and accumulator states for the
// matrix-multiply partial-product path.
package pk_mm_pkg;

    localparam int COEFF_W   = 6;
    localparam int IN_LANES  = 7;
    localparam int OUT_LANES = 4;
    localparam int IDX_W     = 10;

    typedef logic [COEFF_W-1:0] coeff_t;

    typedef enum logic {
        ACCUM,
        DRAIN
    } state_t;

endpackage

// File: rtl/pk_b_accumulator_if.sv
// Stream bundle between the multiply stage, the accumulator and the B sink.
// In: B_valid/idx_B/B_out/B_last, out_ready. Out: B_ready, out_valid/idx/data/last.
interface pk_b_accumulator_if;
    import pk_mm_pkg::*;

    logic                          B_valid;
    logic                          B_ready;
    logic [IDX_W-1:0]              idx_B;
    logic [IN_LANES*COEFF_W-1:0]   B_out;
    logic                          B_last;

    logic                          out_valid;
    logic                          out_ready;
    logic [IDX_W-1:0]              out_idx;
    logic [OUT_LANES*COEFF_W-1:0]  out_data;
    logic                          out_last;

    modport slave (
        input  B_valid, idx_B, B_out, B_last, out_ready,
        output B_ready, out_valid, out_idx, out_data, out_last
    );

    modport master (
        output B_valid, idx_B, B_out, B_last, out_ready,
        input  B_ready, out_valid, out_idx, out_data, out_last
    );

endinterface

// File: rtl/pk_lane_index.sv
// Wraps base+k into 0..DEPTH-1 and flags when the wrap happened.
// Ports: base, k in; p (wrapped index), wrap out. Combinational.
module pk_lane_index
    import pk_mm_pkg::*;
#(
    parameter int DEPTH = 784
) (
    input  logic [IDX_W-1:0] base,
    input  logic [2:0]       k,
    output logic [IDX_W-1:0] p,
    output logic             wrap
);

    localparam logic [IDX_W:0] DEPTH_W = DEPTH[IDX_W:0];

    logic [IDX_W:0] sum;

    always_comb begin
        sum  = {1'b0, base} + {{(IDX_W-2){1'b0}}, k};
        wrap = (sum >= DEPTH_W);
        p    = wrap ? IDX_W'(sum - DEPTH_W) : sum[IDX_W-1:0];
    end

endmodule

// File: rtl/pk_b_accumulator.sv
// Accumulates 7-lane mod-64 partial products into DEPTH coefficients, then
// drains 4 per word and self-clears. Ports: clk_in, rst_in, bus (slave),
// busy, err. Macro NEGACYCLIC_WRAP_EN: wrapped lanes are subtracted.
module pk_b_accumulator
    import pk_mm_pkg::*;
#(
    parameter int DEPTH = 784
) (
    input  logic               clk_in,
    input  logic               rst_in,
    pk_b_accumulator_if.slave  bus,
    output logic               busy,
    output logic               err
);

    localparam logic [IDX_W:0]   DEPTH_W  = DEPTH[IDX_W:0];
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - OUT_LANES);

`ifdef NEGACYCLIC_WRAP_EN
    localparam bit NEG_WRAP = 1'b1;
`else
    localparam bit NEG_WRAP = 1'b0;
`endif

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    coeff_t           acc [DEPTH];

    logic [IDX_W-1:0] lane_p    [IN_LANES];
    logic             lane_wrap [IN_LANES];
    coeff_t           lane_d    [IN_LANES];

    logic beat_hs;
    logic beat_ok;
    logic drain_hs;
    logic at_last;

    for (genvar g = 0; g < IN_LANES; g++) begin : g_lane
        pk_lane_index #(
            .DEPTH (DEPTH)
        ) u_idx (
            .base (bus.idx_B),
            .k    (3'(g)),
            .p    (lane_p[g]),
            .wrap (lane_wrap[g])
        );
    end

    // Lane deltas; in the negacyclic ring x^DEPTH = -1, so wrapped
    // contributions change sign.
    always_comb begin
        for (int k = 0; k < IN_LANES; k++) begin
            lane_d[k] = bus.B_out[k*COEFF_W +: COEFF_W];
            if (NEG_WRAP && lane_wrap[k])
                lane_d[k] = -lane_d[k];
        end
    end

    assign beat_hs  = (state_q == ACCUM) && bus.B_valid;
    assign beat_ok  = beat_hs && ({1'b0, bus.idx_B} < DEPTH_W);
    assign drain_hs = (state_q == DRAIN) && bus.out_ready;
    assign at_last  = (idx_q == LAST_IDX);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            ACCUM: begin
                if (beat_hs && bus.B_last) begin
                    state_d = DRAIN;
                    idx_d   = '0;
                end
            end
            DRAIN: begin
                if (drain_hs) begin
                    if (at_last) begin
                        state_d = ACCUM;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(OUT_LANES);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= ACCUM;
            idx_q   <= '0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (beat_hs && !beat_ok)
                err <= 1'b1;
        end
    end

    // Lane indices of one beat are distinct, so the 7 updates never
    // collide; a following beat reads the already-updated registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++)
                acc[i] <= '0;
        end else begin
            if (beat_ok) begin
                for (int k = 0; k < IN_LANES; k++)
                    acc[lane_p[k]] <= acc[lane_p[k]] + lane_d[k];
            end
            if (drain_hs) begin
                for (int j = 0; j < OUT_LANES; j++)
                    acc[idx_q + IDX_W'(j)] <= '0;
            end
        end
    end

    // Read straight from the accumulator registers; the word only changes
    // after its own handshake, so it holds steady under back-pressure.
    always_comb begin
        bus.out_data = '0;
        if (state_q == DRAIN) begin
            for (int j = 0; j < OUT_LANES; j++)
                bus.out_data[j*COEFF_W +: COEFF_W] = acc[idx_q + IDX_W'(j)];
        end
    end

    assign bus.B_ready   = (state_q == ACCUM);
    assign bus.out_valid = (state_q == DRAIN);
    assign bus.out_idx   = idx_q;
    assign bus.out_last  = (state_q == DRAIN) && at_last;
    assign busy          = (state_q == DRAIN);

endmodule

// File: tb/tb_pk_b_accumulator.sv
// Randomized bench for pk_b_accumulator against an array-based model of the
// coefficient accumulator; each scenario task checks its own results.
module tb_pk_b_accumulator;
    import pk_mm_pkg::*;

    localparam int DEPTH = 784;
    localparam int NW    = DEPTH / 4;

    logic clk_in = 1'b0;
    logic rst_in;
    logic busy;
    logic err;

    pk_b_accumulator_if bif ();

    pk_b_accumulator #(
        .DEPTH (DEPTH)
    ) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bif),
        .busy   (busy),
        .err    (err)
    );

    always #5 clk_in = ~clk_in;

    int          n_pass  = 0;
    int          n_total = 0;
    int          model    [DEPTH];
    logic [23:0] got_data [NW];
    int          got_cnt  [NW];
    logic        got_last [NW];
    int          bad_idx;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    function automatic void model_clear();
        for (int i = 0; i < DEPTH; i++)
            model[i] = 0;
    endfunction

    function automatic void model_beat(int base, logic [41:0] lanes);
        int p;
        int v;
        if (base >= DEPTH)
            return;
        for (int k = 0; k < 7; k++) begin
            p = base + k;
            v = int'(lanes[6*k +: 6]);
            if (p >= DEPTH) begin
                p = p - DEPTH;
`ifdef NEGACYCLIC_WRAP_EN
                v = -v;
`endif
            end
            model[p] = (model[p] + v + 64) % 64;
        end
    endfunction

    function automatic logic [23:0] exp_word(int w);
        logic [23:0] r;
        for (int j = 0; j < 4; j++)
            r[6*j +: 6] = 6'(model[4*w + j]);
        return r;
    endfunction

    function automatic void clear_got();
        bad_idx = 0;
        for (int w = 0; w < NW; w++) begin
            got_data[w] = '0;
            got_cnt[w]  = 0;
            got_last[w] = 1'b0;
        end
    endfunction

    function automatic int drain_errors(bit to);
        int n;
        n = bad_idx + (to ? 1 : 0);
        for (int w = 0; w < NW; w++) begin
            if (got_cnt[w] != 1)
                n++;
            else if (got_data[w] !== exp_word(w))
                n++;
            else if (got_last[w] !== (w == NW - 1))
                n++;
        end
        return n;
    endfunction

    task automatic send_beat(input int base, input logic [41:0] lanes,
                             input logic last);
        bif.B_valid = 1'b1;
        bif.idx_B   = 10'(base);
        bif.B_out   = lanes;
        bif.B_last  = last;
        tick();
        bif.B_valid = 1'b0;
        bif.B_last  = 1'b0;
        model_beat(base, lanes);
    endtask

    // Records drained words with out_ready high until max_words handshakes
    // or the final word; 'to' flags an expired cycle budget.
    task automatic collect_drain(input int max_words, output bit to);
        int   budget;
        int   nhs;
        int   oi;
        logic lst;
        budget = NW + 50;
        nhs    = 0;
        to     = 1'b0;
        bif.out_ready = 1'b1;
        while (nhs < max_words) begin
            if (budget == 0) begin
                to = 1'b1;
                break;
            end
            budget--;
            if (bif.out_valid === 1'b1) begin
                oi  = int'(bif.out_idx);
                lst = bif.out_last;
                if ((oi % 4) != 0 || oi >= DEPTH) begin
                    bad_idx++;
                end else begin
                    got_data[oi/4] = bif.out_data;
                    got_cnt[oi/4]++;
                    got_last[oi/4] = lst;
                end
                nhs++;
                tick();
                if (lst === 1'b1)
                    break;
            end else begin
                tick();
            end
        end
        bif.out_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_in        = 1'b1;
        bif.B_valid   = 1'b0;
        bif.B_last    = 1'b0;
        bif.idx_B     = '0;
        bif.B_out     = '0;
        bif.out_ready = 1'b0;
        tick();
        tick();
        rst_in = 1'b0;
        model_clear();
    endtask

    function automatic logic [41:0] rnd_lanes();
        return 42'({$urandom(), $urandom()});
    endfunction

    task automatic test_reset();
        do_reset();
        n_total++;
        if (bif.B_ready !== 1'b1) $display("FAIL reset_b_ready: got %b want 1", bif.B_ready);
        else n_pass++;
        n_total++;
        if (bif.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bif.out_valid);
        else n_pass++;
        n_total++;
        if (bif.out_idx !== 10'd0) $display("FAIL reset_out_idx: got %0d want 0", bif.out_idx);
        else n_pass++;
        n_total++;
        if (bif.out_data !== 24'd0) $display("FAIL reset_out_data: got %h want 0", bif.out_data);
        else n_pass++;
        n_total++;
        if (bif.out_last !== 1'b0) $display("FAIL reset_out_last: got %b want 0", bif.out_last);
        else n_pass++;
        n_total++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
        else n_pass++;
        n_total++;
        if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err);
        else n_pass++;
    endtask

    task automatic test_single_beat();
        bit to;
        int e;
        send_beat(0, {7{6'd1}}, 1'b1);
        n_total++;
        if (bif.out_valid !== 1'b1 || bif.out_idx !== 10'd0 || busy !== 1'b1
            || bif.B_ready !== 1'b0)
            $display("FAIL single_enter_drain: valid=%b idx=%0d busy=%b rdy=%b want 1 0 1 0",
                     bif.out_valid, bif.out_idx, busy, bif.B_ready);
        else n_pass++;
        n_total++;
        if (bif.out_data !== 24'h041041) $display("FAIL single_word0: got %h want 041041", bif.out_data);
        else n_pass++;
        clear_got();
        collect_drain(NW, to);
        n_total++;
        if (got_data[1] !== 24'h001041) $display("FAIL single_word1: got %h want 001041", got_data[1]);
        else n_pass++;
        n_total++;
        if (got_last[NW-1] !== 1'b1 || got_cnt[NW-1] !== 1)
            $display("FAIL single_last: last=%b cnt=%0d want 1 1", got_last[NW-1], got_cnt[NW-1]);
        else n_pass++;
        e = drain_errors(to);
        n_total++;
        if (e !== 0) $display("FAIL single_drain: got %0d bad words want 0", e);
        else n_pass++;
        n_total++;
        if (bif.B_ready !== 1'b1 || bif.out_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL single_back_to_accum: rdy=%b valid=%b busy=%b want 1 0 0",
                     bif.B_ready, bif.out_valid, busy);
        else n_pass++;
        model_clear();
    endtask

    task automatic test_back_to_back();
        bit to;
        int e;
        send_beat(0, 42'd63, 1'b0);
        send_beat(0, 42'd2, 1'b1);
        clear_got();
        collect_drain(NW, to);
        n_total++;
        if (got_data[0] !== 24'h000001) $display("FAIL b2b_word0: got %h want 000001", got_data[0]);
        else n_pass++;
        e = drain_errors(to);
        n_total++;
        if (e !== 0) $display("FAIL b2b_drain: got %0d bad words want 0", e);
        else n_pass++;
        model_clear();
    endtask

    task automatic test_random();
        bit to;
        int e;
        int base;
        for (int i = 0; i < 60; i++) begin
            base = ($urandom_range(3) == 0) ? int'($urandom_range(DEPTH-1, DEPTH-7))
                                            : int'($urandom_range(DEPTH-1));
            send_beat(base, rnd_lanes(), (i == 59));
            if (i != 59 && $urandom_range(2) == 0)
                tick();
        end
        clear_got();
        collect_drain(NW, to);
        e = drain_errors(to);
        n_total++;
        if (e !== 0) $display("FAIL random_drain: got %0d bad words want 0", e);
        else n_pass++;
        model_clear();
    endtask

    task automatic test_wrap();
        bit          to;
        int          e;
        logic [41:0] l;
        logic [23:0] w0;
        for (int k = 0; k < 7; k++)
            l[6*k +: 6] = 6'(k + 1);
`ifdef NEGACYCLIC_WRAP_EN
        w0 = {6'd0, 6'd57, 6'd58, 6'd59};
`else
        w0 = {6'd0, 6'd7, 6'd6, 6'd5};
`endif
        send_beat(780, l, 1'b1);
        clear_got();
        collect_drain(NW, to);
        n_total++;
        if (got_data[NW-1] !== {6'd4, 6'd3, 6'd2, 6'd1})
            $display("FAIL wrap_word780: got %h want %h", got_data[NW-1], {6'd4, 6'd3, 6'd2, 6'd1});
        else n_pass++;
        n_total++;
        if (got_data[0] !== w0) $display("FAIL wrap_word0: got %h want %h", got_data[0], w0);
        else n_pass++;
        e = drain_errors(to);
        n_total++;
        if (e !== 0) $display("FAIL wrap_drain: got %0d bad words want 0", e);
        else n_pass++;
        model_clear();
    endtask

    task automatic test_stall();
        bit          to;
        int          e;
        int          unstable;
        logic [23:0] w2;
        for (int i = 0; i < 10; i++)
            send_beat(int'($urandom_range(40)), rnd_lanes(), (i == 9));
        clear_got();
        collect_drain(2, to);
        w2 = exp_word(2);
        unstable = 0;
        for (int c = 0; c < 5; c++) begin
            if (bif.out_valid !== 1'b1 || bif.out_idx !== 10'd8
                || bif.out_data !== w2 || bif.B_ready !== 1'b0)
                unstable++;
            tick();
        end
        n_total++;
        if (unstable !== 0 || to)
            $display("FAIL stall_hold: got %0d unstable cycles (idx=%0d data=%h) want 0 (idx 8 data %h)",
                     unstable, bif.out_idx, bif.out_data, w2);
        else n_pass++;
        collect_drain(NW, to);
        e = drain_errors(to);
        n_total++;
        if (e !== 0) $display("FAIL stall_drain: got %0d bad words want 0", e);
        else n_pass++;
        model_clear();
        send_beat(10, rnd_lanes(), 1'b1);
        clear_got();
        collect_drain(NW, to);
        e = drain_errors(to);
        n_total++;
        if (e !== 0) $display("FAIL second_run_drain: got %0d bad words want 0", e);
        else n_pass++;
        model_clear();
    endtask

    task automatic test_err();
        bit to;
        int e;
        send_beat(5, rnd_lanes(), 1'b0);
        send_beat(800, rnd_lanes(), 1'b0);
        n_total++;
        if (err !== 1'b1) $display("FAIL err_set: got %b want 1", err);
        else n_pass++;
        send_beat(700, rnd_lanes(), 1'b1);
        clear_got();
        collect_drain(NW, to);
        n_total++;
        if (err !== 1'b1) $display("FAIL err_sticky: got %b want 1", err);
        else n_pass++;
        e = drain_errors(to);
        n_total++;
        if (e !== 0) $display("FAIL err_drain: got %0d bad words want 0", e);
        else n_pass++;
        model_clear();
    endtask

    task automatic test_mid_reset();
        bit to;
        int e;
        for (int i = 0; i < 5; i++)
            send_beat(int'($urandom_range(DEPTH-1)), rnd_lanes(), (i == 4));
        clear_got();
        collect_drain(25, to);
        n_total++;
        if (bif.out_idx !== 10'd100 || bif.out_valid !== 1'b1)
            $display("FAIL midrst_pos: idx=%0d valid=%b want 100 1", bif.out_idx, bif.out_valid);
        else n_pass++;
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        model_clear();
        n_total++;
        if (bif.out_valid !== 1'b0 || bif.B_ready !== 1'b1 || busy !== 1'b0 || err !== 1'b0)
            $display("FAIL midrst_state: valid=%b rdy=%b busy=%b err=%b want 0 1 0 0",
                     bif.out_valid, bif.B_ready, busy, err);
        else n_pass++;
        send_beat(0, 42'd0, 1'b1);
        clear_got();
        collect_drain(NW, to);
        e = drain_errors(to);
        n_total++;
        if (e !== 0) $display("FAIL midrst_zero_drain: got %0d bad words want 0", e);
        else n_pass++;
    endtask

    initial begin
        rst_in        = 1'b1;
        bif.B_valid   = 1'b0;
        bif.B_last    = 1'b0;
        bif.idx_B     = '0;
        bif.B_out     = '0;
        bif.out_ready = 1'b0;
        test_reset();
        test_single_beat();
        test_back_to_back();
        test_random();
        test_wrap();
        test_stall();
        test_err();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pk_b_accumulator.md
Name: pk_b_accumulator

Overview:
- Receiving end of the partial-product stream from the public/private matrix-multiply stage.
- Each input beat carries 7 packed 6-bit partial-product coefficients plus a base index. The block adds each lane mod 64 into a DEPTH-entry coefficient accumulator at positions base..base+6, wrapping past DEPTH.
- After the final beat it drains the completed B vector downstream, 4 coefficients per word, matching the packed 24-bit public-key word format. It then self-clears for the next run.

Parameters:
DEPTH, 784, number of 6-bit coefficients in the accumulator (multiple of 4, ≤1024)

Ports:
clk_in  input  1  clock
rst_in  input  1  reset, synchronous, active-high
B_valid  input  1  input beat valid
B_ready  output  1  block accepts input beat
idx_B  input  10  base coefficient index of beat
B_out  input  42  7 lanes; lane k = bits [6k+5:6k]
B_last  input  1  final beat of run (qualified by B_valid)
out_valid  output  1  drain word valid
out_ready  input  1  downstream accepts drain word
out_idx  output  10  index of out_data lane 0 (multiple of 4)
out_data  output  24  4 coeffs; lane j = acc[out_idx+j] at bits [6j+5:6j]
out_last  output  1  final drain word (out_idx = DEPTH-4)
busy  output  1  high in DRAIN
err  output  1  sticky: a beat had idx_B ≥ DEPTH

Behaviour:
- Reset (rst_in=1 at clk edge):
  - State ACCUM; all acc entries = 0.
  - B_ready=1; out_valid=0, out_idx=0, out_data=0, out_last=0, busy=0, err=0.
  - Applies in any state, including mid-drain; the run in progress is lost.
- States: ACCUM, DRAIN.
- ACCUM:
  - B_ready=1.
  - Beat accepted when B_valid&B_ready.
  - For k=0..6: p=idx_B+k; if p≥DEPTH then p-=DEPTH; acc[p] <= acc[p]+lane_k (6-bit truncation).
  - All 7 updates happen in the same cycle. Back-to-back beats with overlapping indices must accumulate exactly; no bubbles or hazards.
  - idx_B ≥ DEPTH: beat consumed, acc unchanged, err set (sticky until reset).
  - Accepted beat with B_last=1: update applied, then DRAIN next cycle, with out_valid=1, out_idx=0.
- DRAIN:
  - B_ready=0; busy=1.
  - out_data is registered and stable while out_valid&!out_ready.
  - On a handshake, out_idx += 4 and the next word is presented the following cycle (one word per cycle at full throughput).
  - out_last=1 exactly when out_idx=DEPTH-4.
  - Each drained word's 4 entries are zeroed on its handshake.
  - After the last handshake: out_valid=0, state ACCUM, B_ready=1 next cycle.
  - A drain takes DEPTH/4 handshakes (196 at default).
- Arithmetic: all coefficient math is mod 64. No saturation, no carry between lanes.

Optional Feature:
- Macro: NEGACYCLIC_WRAP_EN.
- Defined: a lane whose index wraps (idx_B+k ≥ DEPTH) is subtracted, acc[p] <= acc[p]-lane_k mod 64 (ring x^DEPTH = -1).
- Undefined: wrapped lanes are added (cyclic).
- Non-wrapping lanes are identical in both builds.

Decomposition:
- Shared package pk_mm_pkg holds:
  - COEFF_W=6, IN_LANES=7, OUT_LANES=4, IDX_W=10
  - typedef coeff_t
  - state enum {ACCUM, DRAIN}
- Sub-module pk_lane_index: combinational; inputs base, k, DEPTH; outputs wrapped index p and wrap flag. Instantiated 7 times.

Test Plan:
- Single beat idx_B=0, all lanes=1, B_last=1 → word0 out_data=24'h041041 (out_idx=0); word1=24'h001041 (out_idx=4); remaining words 0; out_last on out_idx=780.
- Beats idx_B=0 lane0=63, then back-to-back idx_B=0 lane0=2 (last) → acc[0]=1, out_data word0 = 24'h000001.
- idx_B=780, lanes 1..7, last → word 780 = {4,3,2,1} lanes.
  - Cyclic build: word0 lanes = 5,6,7,0.
  - NEGACYCLIC_WRAP_EN build: word0 lanes = 59,58,57,0.
- In DRAIN, hold out_ready=0 for 5 cycles at out_idx=8 → out_valid=1, out_idx and out_data stable, B_ready=0; resume gives no skipped or duplicated words. A second run after the drain starts from all-zero acc.
- idx_B=800 beat → err=1, acc unchanged; err stays 1 through the drain.
- rst_in=1 at out_idx=100 mid-drain → next cycle out_valid=0, B_ready=1, busy=0. A fresh run with no beats before last drains all zeros.
